// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared types and constants for the receive frame FIFO.
//   rx_state_e  - write-side frame state (IDLE, FRAME, DROP)
//   DROP_CNT_W  - width of the saturating dropped-frame counter
//   ptr_width() - pointer width for a given depth (address bits + wrap bit)
package rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } rx_state_e;

  localparam int unsigned DROP_CNT_W = 16;

  // One extra bit beyond the address lets full and empty be told apart on wrap.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port storage, registered write, asynchronous read.
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational from i_raddr)
module fifo_sdp_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: single-clock frame FIFO. Bytes are written speculatively and
// become visible only once the frame's last byte is accepted; overflowed or
// aborted frames are rewound and dropped whole.
//   clkIn, rstIn        - clock, synchronous active-high reset
//   wrDataIn/ValidIn/LastIn/AbortIn - write side, no backpressure
//   rdDataOut/ValidOut/LastOut, rdReadyIn - first-word-fall-through read side
//   almostFullOut       - registered, occupancy >= AFULL_LEVEL
//   overflowOut         - one-cycle pulse after a write hit a full buffer
//   frameCountOut       - committed frames not yet fully read
//   dropCountOut        - dropped frames, saturating
module rx_frame_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = DEPTH - 4
) (
  input  logic                                clkIn,
  input  logic                                rstIn,
  input  logic [DATA_WIDTH-1:0]               wrDataIn,
  input  logic                                wrValidIn,
  input  logic                                wrLastIn,
  input  logic                                wrAbortIn,
  output logic [DATA_WIDTH-1:0]               rdDataOut,
  output logic                                rdValidOut,
  output logic                                rdLastOut,
  input  logic                                rdReadyIn,
  output logic                                almostFullOut,
  output logic                                overflowOut,
  output logic [$clog2(DEPTH+1)-1:0]          frameCountOut,
  output logic [rx_fifo_pkg::DROP_CNT_W-1:0]  dropCountOut
);
  import rx_fifo_pkg::*;

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = ptr_width(DEPTH);
  localparam int unsigned FCW = $clog2(DEPTH + 1);

  logic [PW-1:0]         r_wrPtr, r_commitPtr, r_rdPtr;
  rx_state_e             r_state;
  logic                  r_afull, r_overflow;
  logic [FCW-1:0]        r_frameCount;
  logic [DROP_CNT_W-1:0] r_dropCount;

  logic [PW-1:0]         w_occ, w_wrPtrNext, w_rdPtrNext, w_occNext;
  logic                  w_full, w_abort, w_ovfHit, w_wrAccept, w_commit;
  logic                  w_rewind, w_pop, w_popLast;
  logic [DATA_WIDTH:0]   w_ramRd;

  assign w_occ      = r_wrPtr - r_rdPtr;
  assign w_full     = (w_occ == PW'(DEPTH));
  assign rdValidOut = (r_commitPtr != r_rdPtr);

  always_comb begin
    // Abort outranks overflow and last so every failed frame is counted once.
    w_abort    = wrAbortIn && ((r_state == FRAME) || ((r_state == IDLE) && wrValidIn));
    w_ovfHit   = !w_abort && (r_state != DROP) && wrValidIn && w_full;
    w_wrAccept = !w_abort && (r_state != DROP) && wrValidIn && !w_full;
    w_commit   = w_wrAccept && wrLastIn;
    w_rewind   = w_abort || w_ovfHit;
    w_pop      = rdValidOut && rdReadyIn;
    w_popLast  = w_pop && w_ramRd[DATA_WIDTH];

    w_wrPtrNext = r_wrPtr;
    if (w_rewind) begin
      w_wrPtrNext = r_commitPtr;
    end else if (w_wrAccept) begin
      w_wrPtrNext = r_wrPtr + PW'(1);
    end
    w_rdPtrNext = w_pop ? (r_rdPtr + PW'(1)) : r_rdPtr;
    // Registering next-cycle occupancy keeps almostFullOut aligned with the pointers.
    w_occNext   = w_wrPtrNext - w_rdPtrNext;
  end

  fifo_sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clkIn),
    .i_we    (w_wrAccept),
    .i_waddr (r_wrPtr[AW-1:0]),
    .i_wdata ({wrLastIn, wrDataIn}),
    .i_raddr (r_rdPtr[AW-1:0]),
    .o_rdata (w_ramRd)
  );

  assign rdDataOut     = rdValidOut ? w_ramRd[DATA_WIDTH-1:0] : '0;
  assign rdLastOut     = rdValidOut & w_ramRd[DATA_WIDTH];
  assign almostFullOut = r_afull;
  assign overflowOut   = r_overflow;
  assign frameCountOut = r_frameCount;
  assign dropCountOut  = r_dropCount;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_wrPtr      <= '0;
      r_commitPtr  <= '0;
      r_rdPtr      <= '0;
      r_state      <= IDLE;
      r_afull      <= 1'b0;
      r_overflow   <= 1'b0;
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      r_wrPtr    <= w_wrPtrNext;
      r_rdPtr    <= w_rdPtrNext;
      r_overflow <= w_ovfHit;
      r_afull    <= (w_occNext >= PW'(AFULL_LEVEL));

      if (w_commit) begin
        r_commitPtr <= r_wrPtr + PW'(1);
      end

      if (w_rewind && (r_dropCount != '1)) begin
        r_dropCount <= r_dropCount + DROP_CNT_W'(1);
      end

      if (w_commit && !w_popLast) begin
        r_frameCount <= r_frameCount + FCW'(1);
      end else if (!w_commit && w_popLast) begin
        r_frameCount <= r_frameCount - FCW'(1);
      end

      case (r_state)
        IDLE, FRAME: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (wrValidIn) begin
            if (w_full) begin
              r_state <= wrLastIn ? IDLE : DROP;
            end else begin
              r_state <= wrLastIn ? IDLE : FRAME;
            end
          end
        end
        DROP: begin
          if (wrValidIn && wrLastIn) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
module tb_rx_frame_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk = 1'b0;
  logic        rstIn;
  logic [7:0]  wrDataIn;
  logic        wrValidIn, wrLastIn, wrAbortIn, rdReadyIn;
  logic [7:0]  rdDataOut;
  logic        rdValidOut, rdLastOut, almostFullOut, overflowOut;
  logic [4:0]  frameCountOut;
  logic [15:0] dropCountOut;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  // Reference model: committed bytes visible to the reader, plus the bytes of
  // the frame currently being written.
  logic [8:0] m_com[$];
  logic [8:0] m_pend[$];
  bit m_inframe, m_dropping, m_ovf;
  int m_drops;

  rx_frame_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clkIn         (clk),
    .rstIn         (rstIn),
    .wrDataIn      (wrDataIn),
    .wrValidIn     (wrValidIn),
    .wrLastIn      (wrLastIn),
    .wrAbortIn     (wrAbortIn),
    .rdDataOut     (rdDataOut),
    .rdValidOut    (rdValidOut),
    .rdLastOut     (rdLastOut),
    .rdReadyIn     (rdReadyIn),
    .almostFullOut (almostFullOut),
    .overflowOut   (overflowOut),
    .frameCountOut (frameCountOut),
    .dropCountOut  (dropCountOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_frames();
    int n = 0;
    foreach (m_com[i]) if (m_com[i][8]) n++;
    return n;
  endfunction

  task automatic m_drop_frame();
    m_pend.delete();
    m_inframe = 0;
    if (m_drops < 65535) m_drops++;
  endtask

  always @(posedge clk) begin : model
    bit pop, full;
    if (rstIn) begin
      m_com.delete();
      m_pend.delete();
      m_inframe  = 0;
      m_dropping = 0;
      m_ovf      = 0;
      m_drops    = 0;
    end else begin
      pop   = (m_com.size() > 0) && rdReadyIn;
      full  = (m_com.size() + m_pend.size()) == DEPTH;
      m_ovf = 0;
      if (pop) void'(m_com.pop_front());
      if (m_dropping) begin
        if (wrValidIn && wrLastIn) m_dropping = 0;
      end else if (wrAbortIn && (m_inframe || wrValidIn)) begin
        m_drop_frame();
      end else if (wrValidIn) begin
        if (full) begin
          m_ovf = 1;
          m_drop_frame();
          m_dropping = !wrLastIn;
        end else begin
          m_pend.push_back({wrLastIn, wrDataIn});
          if (wrLastIn) begin
            foreach (m_pend[i]) m_com.push_back(m_pend[i]);
            m_pend.delete();
            m_inframe = 0;
          end else begin
            m_inframe = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("rdValid",    rdValidOut,    (m_com.size() > 0));
      chk("rdData",     rdDataOut,     (m_com.size() > 0) ? m_com[0][7:0] : 8'h00);
      chk("rdLast",     rdLastOut,     (m_com.size() > 0) ? m_com[0][8] : 1'b0);
      chk("almostFull", almostFullOut, ((m_com.size() + m_pend.size()) >= AFULL));
      chk("overflow",   overflowOut,   m_ovf);
      chk("frameCount", frameCountOut, m_frames());
      chk("dropCount",  dropCountOut,  m_drops);
    end
  end

  task automatic tick(input logic v, input logic [7:0] d, input logic l,
                      input logic a, input logic r);
    wrValidIn = v;
    wrDataIn  = d;
    wrLastIn  = l;
    wrAbortIn = a;
    rdReadyIn = r;
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstIn = 1'b1;
    tick(0, 8'h00, 0, 0, 0);
    rstIn = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, rdValidOut,    0);
    chk({tag, "_data"},  rdDataOut,     0);
    chk({tag, "_last"},  rdLastOut,     0);
    chk({tag, "_afull"}, almostFullOut, 0);
    chk({tag, "_ovf"},   overflowOut,   0);
    chk({tag, "_fc"},    frameCountOut, 0);
    chk({tag, "_dc"},    dropCountOut,  0);
  endtask

  initial begin
    int ovf_seen, valid_seen, afull_seen;
    logic [7:0] t3 [3];
    logic v, l, a, r;
    t3[0] = 8'hA1; t3[1] = 8'hA2; t3[2] = 8'hA3;

    rstIn = 1'b1; wrValidIn = 0; wrDataIn = 0; wrLastIn = 0; wrAbortIn = 0; rdReadyIn = 0;
    @(negedge clk); #2;
    do_reset();
    check_en = 1;
    chk_reset_outputs("rst");

    // 5-byte frame, reader always ready
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(1, 8'(i), 0, 0, 1);
      chk("t1_early_valid", rdValidOut, 0);
    end
    tick(1, 8'h05, 1, 0, 1);
    chk("t1_fc_commit", frameCountOut, 1);
    for (int k = 1; k <= 5; k++) begin
      chk("t1_valid", rdValidOut, 1);
      chk("t1_data",  rdDataOut, k);
      chk("t1_last",  rdLastOut, (k == 5));
      tick(0, 8'h00, 0, 0, 1);
    end
    chk("t1_fc_end", frameCountOut, 0);
    chk("t1_valid_end", rdValidOut, 0);

    // 20-byte frame into a 16-entry buffer, no reads
    do_reset();
    ovf_seen = 0; valid_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1, 8'(i), (i == 20), 0, 0);
      ovf_seen += int'(overflowOut);
      valid_seen |= int'(rdValidOut);
      if (i == 17) chk("t2_ovf_after17", overflowOut, 1);
    end
    tick(0, 8'h00, 0, 0, 0);
    ovf_seen += int'(overflowOut);
    chk("t2_ovf_pulses", ovf_seen, 1);
    chk("t2_dc", dropCountOut, 1);
    chk("t2_never_valid", valid_seen, 0);
    chk("t2_afull_empty", almostFullOut, 0);

    // committed 3-byte frame, then a 4-byte frame aborted on byte 3
    do_reset();
    tick(1, 8'hA1, 0, 0, 0);
    tick(1, 8'hA2, 0, 0, 0);
    tick(1, 8'hA3, 1, 0, 0);
    tick(1, 8'hB1, 0, 0, 0);
    tick(1, 8'hB2, 0, 0, 0);
    tick(1, 8'hB3, 0, 1, 0);
    chk("t3_fc", frameCountOut, 1);
    chk("t3_dc", dropCountOut, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t3_data", rdDataOut, t3[k]);
      chk("t3_last", rdLastOut, (k == 2));
      tick(0, 8'h00, 0, 0, 1);
    end
    chk("t3_valid_end", rdValidOut, 0);
    chk("t3_fc_end", frameCountOut, 0);

    // abort together with last, from IDLE and from FRAME
    do_reset();
    tick(1, 8'hC1, 1, 1, 0);
    chk("t4_dc_idle", dropCountOut, 1);
    chk("t4_fc_idle", frameCountOut, 0);
    tick(1, 8'hC2, 0, 0, 0);
    tick(1, 8'hC3, 1, 1, 0);
    chk("t4_dc_frame", dropCountOut, 2);
    chk("t4_fc_frame", frameCountOut, 0);
    chk("t4_valid", rdValidOut, 0);

    // back-to-back 8-byte frames with continuous reads across several wraps
    do_reset();
    afull_seen = 0;
    for (int f = 0; f < 14; f++) begin
      for (int b = 0; b < 8; b++) begin
        tick(1, 8'(f * 8 + b), (b == 7), 0, 1);
        afull_seen |= int'(almostFullOut);
      end
    end
    repeat (12) begin
      tick(0, 8'h00, 0, 0, 1);
      afull_seen |= int'(almostFullOut);
    end
    chk("t5_afull_never", afull_seen, 0);
    chk("t5_fc_end", frameCountOut, 0);
    chk("t5_dc", dropCountOut, 0);

    // reset in the middle of reading a committed frame
    do_reset();
    tick(1, 8'hE1, 0, 0, 0);
    tick(1, 8'hE2, 0, 0, 0);
    tick(1, 8'hE3, 0, 0, 0);
    tick(1, 8'hE4, 1, 0, 0);
    tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk("t6_mid_data", rdDataOut, 8'hE3);
    rstIn = 1'b1;
    tick(0, 8'h00, 0, 0, 1);
    rstIn = 1'b0;
    chk_reset_outputs("t6_rst");
    tick(1, 8'hD1, 0, 0, 0);
    tick(1, 8'hD2, 1, 0, 0);
    chk("t6_d1", rdDataOut, 8'hD1);
    chk("t6_fc", frameCountOut, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk("t6_d2", rdDataOut, 8'hD2);
    chk("t6_d2_last", rdLastOut, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk("t6_valid_end", rdValidOut, 0);
    chk("t6_fc_end", frameCountOut, 0);

    // randomized traffic: slow reader first (overflows), then fast reader
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(99) < 65);
      l = v && ($urandom_range(5) == 0);
      a = ($urandom_range(49) == 0);
      r = ($urandom_range(99) < ((n < 2000) ? 25 : 85));
      tick(v, 8'($urandom), l, a, r);
    end
    repeat (DEPTH + 4) tick(0, 8'h00, 0, 0, 1);
    chk("rand_drained", rdValidOut, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_fifo.md
# rx_frame_fifo

Single-clock, parametrised frame FIFO for the receive path, placed after the 125→250 MHz crossing and ahead of the MAC parser in the 250 MHz domain. Bytes are written speculatively and become visible to the reader only when the frame's last byte is accepted. Frames that overflow the buffer or are aborted are rewound and dropped whole, so the reader never sees a partial frame. Frame and drop counters support link monitoring.

## Interface
- DATA_WIDTH, 8, payload bits per entry; the last flag is stored alongside.
- DEPTH, 16, entries; power of two, ≥ 4.
- AFULL_LEVEL, DEPTH-4, occupancy at or above which almostFullOut asserts.
- clkIn  in  1  single clock (250 MHz domain).
- rstIn  in  1  reset; synchronous, active-high.
- wrDataIn  in  DATA_WIDTH  write data.
- wrValidIn  in  1  write strobe; no backpressure.
- wrLastIn  in  1  qualifies the final byte of a frame.
- wrAbortIn  in  1  discard the frame in progress.
- rdDataOut  out  DATA_WIDTH  head data, first-word-fall-through.
- rdValidOut  out  1  head holds a committed byte.
- rdLastOut  out  1  head byte is the last of its frame.
- rdReadyIn  in  1  pop when rdValidOut && rdReadyIn.
- almostFullOut  out  1  registered, occupancy ≥ AFULL_LEVEL.
- overflowOut  out  1  one-cycle pulse when a write hits a full buffer.
- frameCountOut  out  $clog2(DEPTH+1)  committed frames not yet fully read.
- dropCountOut  out  16  dropped frames, saturating at 0xFFFF.

## Operation
- Pointers wrPtr (speculative), commitPtr, rdPtr; each is AW+1 bits, where AW = $clog2(DEPTH). Storage is indexed by the low AW bits; the MSB distinguishes full from empty on wrap.
- Occupancy = wrPtr − rdPtr, modulo 2^(AW+1). Full when occupancy == DEPTH. rdValidOut = (commitPtr != rdPtr).
- FSM states:
  - IDLE: between frames.
  - FRAME: frame in progress.
  - DROP: discarding the remainder of a failed frame.
- IDLE or FRAME, with wrValidIn and not full:
  - Store {wrLastIn, wrDataIn}; wrPtr++.
  - If wrLastIn: commitPtr ← wrPtr+1, frameCount++, go to IDLE. Otherwise go to FRAME.
- IDLE or FRAME, with wrValidIn and full:
  - Pulse overflowOut; wrPtr ← commitPtr; dropCount++.
  - Go to IDLE if wrLastIn, else DROP.
- wrAbortIn in FRAME, or in IDLE together with wrValidIn: wrPtr ← commitPtr; dropCount++; go to IDLE. Abort takes priority over last and over overflow, so each frame is counted once.
- wrAbortIn in IDLE without wrValidIn: no effect.
- DROP: ignore all data and abort; go to IDLE on wrValidIn && wrLastIn.
- A frame longer than DEPTH always overflows and is dropped.
- Full is evaluated from registered state. A write to a full buffer overflows even if a pop occurs in the same cycle.
- frameCount: +1 on commit, −1 on popping a last byte; a simultaneous commit and pop leaves it unchanged.

## Timing
- Reset values: all pointers 0, state IDLE, rdValidOut 0, rdLastOut 0, rdDataOut 0 (masked while not valid), almostFullOut 0, overflowOut 0, frameCountOut 0, dropCountOut 0.
- A frame whose last byte is written in cycle N shows rdValidOut = 1 in cycle N+1, with its first byte on rdDataOut.
- rdDataOut/rdLastOut are combinational reads of storage at rdPtr. A pop in cycle N presents the next entry in N+1.
- Read and write in the same cycle are allowed, including at wrap-around.
- overflowOut is registered and asserts in the cycle after the offending write.
- rstIn mid-frame discards everything, committed frames included.

## Structure
- Package rx_fifo_pkg holds:
  - the FSM state enum (IDLE, FRAME, DROP);
  - the dropCount width constant;
  - a helper function computing the pointer width.
- Sub-module fifo_sdp_ram: a simple dual-port array with a registered write and an asynchronous read, mapping to distributed RAM.
- Pointer, FSM and counter logic live in rx_frame_fifo.

## Test plan
- 5-byte frame 0x01..0x05 with last on 0x05, rdReadyIn=1:
  - rdValidOut stays 0 until the cycle after 0x05 is written.
  - Output is 0x01..0x05 on consecutive cycles, rdLastOut on 0x05.
  - frameCountOut goes 1→0.
- DEPTH=16, rdReadyIn=0, 20-byte frame: overflowOut pulses once after byte 17; dropCountOut=1; rdValidOut never asserts; occupancy returns to 0.
- 3-byte frame committed, then a 4-byte frame aborted on byte 3: reader receives exactly the 3-byte frame; dropCountOut=1; frameCountOut=1 before reading.
- Abort and last asserted on the same byte: frame dropped, frameCountOut unchanged, dropCountOut +1.
- Back-to-back 8-byte frames with continuous reads across ≥3 pointer wraps: data order preserved; almostFullOut never asserts.
- rstIn asserted mid-read of a committed frame: next cycle all outputs are at reset values; a following 2-byte frame reads out correctly.
